cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Miss-handling controller that sits between the CPU request port and the set-associative cache array. It accepts one CPU load/store at a time, probes the cache, and on a read miss fetches the word from backing memory over a valid/ready handshake. It then writes the word into the cache and returns it to the CPU. Stores are write-through, and a memory-response timeout plus saturating hit/miss counters are included for debug.

## Interface
- ADDR_WIDTH, 8, address width, identical to the cache.
- DATA_WIDTH, 32, data word width.
- TIMEOUT, 255, maximum cycles spent in MEM_WAIT before an error response; minimum 1.
- CNT_WIDTH, 16, width of the hit/miss statistics counters.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_addr  in  ADDR_WIDTH  request address.
- cpu_we  in  1  0 = load, 1 = store.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_resp_err  out  1  qualifies cpu_resp_valid: memory timeout.
- cpu_rdata  out  DATA_WIDTH  load data; 0 for stores and errors.
- cache_en  out  1  one-cycle cache access strobe.
- cache_rw  out  1  0 = probe/read, 1 = write.
- cache_addr  out  ADDR_WIDTH  cache address.
- cache_wdata  out  DATA_WIDTH  cache write data.
- cache_hit  in  1  cache hit, valid the cycle after cache_en.
- cache_rdata  in  DATA_WIDTH  cache read data, valid with cache_hit.
- mem_req_valid  out  1  memory request present.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_resp_valid  in  1  memory read data valid; ignored for writes.
- mem_rdata  in  DATA_WIDTH  memory read data.
- hit_count, miss_count  out  CNT_WIDTH  saturating statistics.

## Operation
- The request is latched on cpu_req_valid && cpu_req_ready. cpu_req_ready = 1 only in IDLE.
- States: IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP.
- **IDLE:** on accept, go to LOOKUP.
- **LOOKUP:** cache_en = 1, cache_rw = latched we, cache_addr/cache_wdata = latched values. Go to CHECK.
- **CHECK:** sample cache_hit/cache_rdata.
  - Load hit: capture rdata, hit_count++, go to RESP.
  - Load miss: miss_count++, go to MEM_REQ (mem_we = 0).
  - Store: hit_count++ on hit, else miss_count++. Go to MEM_REQ (mem_we = 1). Stores are write-through, and the cache line was already updated or allocated by the LOOKUP write.
- **MEM_REQ:** mem_req_valid = 1, with address/data/we held stable until mem_req_ready.
  - On the handshake, a store goes to RESP and a load goes to MEM_WAIT with the timeout counter cleared.
- **MEM_WAIT:** the counter increments each cycle.
  - On mem_resp_valid: capture mem_rdata and go to FILL.
  - When the counter reaches TIMEOUT without a response: set err and go to RESP. Rdata = 0 and the cache is not filled.
- **FILL:** cache_en = 1, cache_rw = 1, cache_wdata = fetched word, then go to RESP.
- **RESP:** cpu_resp_valid = 1 for exactly one cycle, with cpu_rdata/cpu_resp_err registered, then go to IDLE.
- A mem_resp_valid that arrives in the same cycle the timeout expires counts as a valid response, not an error.
- mem_resp_valid outside MEM_WAIT is ignored. A stale response after a timeout is dropped.
- Counters stop at 2^CNT_WIDTH−1 and never wrap.
- Reset mid-transaction returns to IDLE immediately. Any outstanding memory response is then ignored.

## Timing
- **Reset values:** state IDLE; cpu_req_ready 0 during rst, 1 in the first cycle after release; every other output 0; counters 0.
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths except none.
- Cache contract: cache_hit/cache_rdata are sampled in the cycle immediately after the cache_en cycle.
- **Load hit:** accept at edge E0; LOOKUP during E0–E1; CHECK during E1–E2; cpu_resp_valid high during E2–E3. Latency is 3 cycles.
- **Load miss:** 3 + (cycles waiting mem_req_ready) + (memory latency) + 1 (FILL).
- **Store:** 3 + (cycles waiting mem_req_ready).
- Back-to-back throughput: at most one request per 4 cycles, since ready returns the cycle after RESP.
- mem_req_valid must not deassert before mem_req_ready, and its payload must stay constant.

## Test plan
- **Reset:** assert rst mid-MEM_WAIT → next cycle state IDLE, all outputs 0. After release, cpu_req_ready = 1 and counters = 0.
- **Load miss then hit:** load 0x2C with memory returning 0xDEADBEEF after 5 cycles → FILL writes 0xDEADBEEF, resp rdata 0xDEADBEEF, miss_count = 1. A repeat load of 0x2C → resp at 3 cycles with 0xDEADBEEF, hit_count = 1, mem_req_valid never asserted.
- **Store write-through:** store 0x55AA55AA to 0x10 with mem_req_ready held low for 4 cycles → mem_req_valid held with stable payload, mem_we = 1, resp err = 0 and rdata = 0 one cycle after the handshake.
- **Timeout:** TIMEOUT = 8 and memory never responds → cpu_resp_err = 1, rdata = 0, no FILL strobe. A late mem_resp_valid is ignored, and the next request is accepted normally.
- **Boundary:** mem_resp_valid in exactly the timeout cycle → normal response with data, err = 0.
- **Saturation:** CNT_WIDTH = 2 with 5 load hits → hit_count stays at 3.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: single-outstanding miss handler between the CPU port,
// the cache array and backing memory. Loads that hit return from the cache.
// Load misses fetch the word from memory, fill the cache, then respond.
// Stores write the cache in LOOKUP and are written through to memory.
// A timeout in MEM_WAIT produces an error response. Hit and miss counters
// saturate at their maximum value.
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // CPU request / response
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_resp_valid,
  output logic                  cpu_resp_err,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  // Cache array
  output logic                  cache_en,
  output logic                  cache_rw,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  // Backing memory
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  // Debug statistics
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  // Timeout counter counts 0 .. TIMEOUT-1 while waiting; the cycle it holds
  // TIMEOUT-1 is the last one in which a memory response is still accepted.
  localparam int                 TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_FILL,
    S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
  logic                   we_q,    we_d;
  // Store data for a store, fetched word for a load miss (drives cache_wdata).
  logic [DATA_WIDTH-1:0]  data_q,  data_d;
  // Load result returned to the CPU; stays 0 for stores and timeouts.
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q,   err_d;
  logic [TMO_W-1:0]       tmo_q,   tmo_d;
  logic [CNT_WIDTH-1:0]   hit_q,   hit_d;
  logic [CNT_WIDTH-1:0]   miss_q,  miss_d;

  logic accept;

  assign accept = cpu_req_valid && ready_q;

  // Next-state and datapath update for the request sequencer.
  always_comb begin
    // NOTE: every _d is given its hold value first, so no branch can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    hit_d   = hit_q;
    miss_d  = miss_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          data_d  = cpu_we ? cpu_wdata : '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (cache_hit) begin
          if (hit_q != '1) hit_d = hit_q + 1'b1;
        end else begin
          if (miss_q != '1) miss_d = miss_q + 1'b1;
        end
        if (!we_q && cache_hit) begin
          rdata_d = cache_rdata;
          state_d = S_RESP;
        end else begin
          // Load misses fetch; stores write through (cache already updated).
          state_d = S_MEM_REQ;
        end
      end

      S_MEM_REQ: begin
        if (mem_req_ready) begin
          tmo_d   = '0;
          state_d = we_q ? S_RESP : S_MEM_WAIT;
        end
      end

      S_MEM_WAIT: begin
        // A response in the final allowed cycle still wins over the timeout.
        if (mem_resp_valid) begin
          data_d  = mem_rdata;
          rdata_d = mem_rdata;
          state_d = S_FILL;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_FILL: begin
        state_d = S_RESP;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ready is registered so it reads 0 while rst is held and rises on the
    // first edge after release, then tracks the IDLE state exactly.
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Outputs are decoded from the state register and latched request fields
  // only, so no input reaches an output combinationally.
  assign cpu_req_ready  = ready_q;

  assign cache_en       = (state_q == S_LOOKUP) || (state_q == S_FILL);
  assign cache_rw       = (state_q == S_LOOKUP) ? we_q : (state_q == S_FILL);
  assign cache_addr     = cache_en ? addr_q : '0;
  assign cache_wdata    = cache_en ? data_q : '0;

  assign mem_req_valid  = (state_q == S_MEM_REQ);
  assign mem_we         = mem_req_valid && we_q;
  assign mem_addr       = mem_req_valid ? addr_q : '0;
  assign mem_wdata      = mem_we ? data_q : '0;

  assign cpu_resp_valid = (state_q == S_RESP);
  assign cpu_resp_err   = cpu_resp_valid && err_q;
  assign cpu_rdata      = cpu_resp_valid ? rdata_q : '0;

  assign hit_count      = hit_q;
  assign miss_count     = miss_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl (TIMEOUT = 8, CNT_WIDTH = 2).
// A small cache-array model answers cache probes; memory is driven by hand.
module tb_cache_refill_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_resp_valid;
  logic          cpu_resp_err;
  logic [DW-1:0] cpu_rdata;
  logic          cache_en;
  logic          cache_rw;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata;
  logic          cache_hit;
  logic [DW-1:0] cache_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  int n_pass  = 0;
  int n_total = 0;

  cache_refill_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (8),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_addr       (cpu_addr),
    .cpu_we         (cpu_we),
    .cpu_wdata      (cpu_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_err   (cpu_resp_err),
    .cpu_rdata      (cpu_rdata),
    .cache_en       (cache_en),
    .cache_rw       (cache_rw),
    .cache_addr     (cache_addr),
    .cache_wdata    (cache_wdata),
    .cache_hit      (cache_hit),
    .cache_rdata    (cache_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache array model: answers a probe the cycle after cache_en, hit reflects
  // the line state before any write in the same access.
  bit            cache_vld [0:255];
  logic [DW-1:0] cache_mem [0:255];

  always @(posedge clk) begin
    if (cache_en) begin
      cache_hit   <= cache_vld[cache_addr];
      cache_rdata <= cache_vld[cache_addr] ? cache_mem[cache_addr] : '0;
      if (cache_rw) begin
        cache_vld[cache_addr] <= 1'b1;
        cache_mem[cache_addr] <= cache_wdata;
      end
    end else begin
      cache_hit   <= 1'b0;
      cache_rdata <= '0;
    end
  end

  // Activity monitors: cycles with a memory request and cycles with a cache write.
  int mem_req_cycles = 0;
  int fill_cycles    = 0;

  always @(posedge clk) begin
    if (mem_req_valid)         mem_req_cycles++;
    if (cache_en && cache_rw)  fill_cycles++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge (LOOKUP).
  task automatic issue(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
    int n = 0;
    while (!cpu_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_issue", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_addr      = a;
    cpu_we        = we;
    cpu_wdata     = wd;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_we        = 1'b0;
    cpu_wdata     = '0;
  endtask

  int snap;

  initial begin
    rst            = 1'b1;
    cpu_req_valid  = 1'b0;
    cpu_addr       = '0;
    cpu_we         = 1'b0;
    cpu_wdata      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;

    // ---- Power-on reset ----
    @(negedge clk);
    check("por_ready",      cpu_req_ready, 0);
    check("por_resp_valid", cpu_resp_valid, 0);
    check("por_cache_en",   cache_en, 0);
    check("por_mem_req",    mem_req_valid, 0);
    check("por_hit",        hit_count, 0);
    check("por_miss",       miss_count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("por_ready_after", cpu_req_ready, 1);

    // ---- Reset in the middle of MEM_WAIT ----
    issue(8'h40, 1'b0, '0);
    check("r_lookup_en",   cache_en, 1);
    check("r_lookup_rw",   cache_rw, 0);
    check("r_lookup_addr", cache_addr, 8'h40);
    @(negedge clk);
    @(negedge clk);
    check("r_mreq_valid", mem_req_valid, 1);
    check("r_mreq_addr",  mem_addr, 8'h40);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("r_wait_mreq_low", mem_req_valid, 0);
    check("r_wait_miss",     miss_count, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("r_mid_ready",      cpu_req_ready, 0);
    check("r_mid_mem_req",    mem_req_valid, 0);
    check("r_mid_cache_en",   cache_en, 0);
    check("r_mid_resp_valid", cpu_resp_valid, 0);
    check("r_mid_resp_err",   cpu_resp_err, 0);
    check("r_mid_rdata",      cpu_rdata, 0);
    check("r_mid_miss",       miss_count, 0);
    check("r_mid_hit",        hit_count, 0);
    snap = fill_cycles;
    rst            = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1234_5678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    check("r_rel_ready",      cpu_req_ready, 1);
    check("r_rel_resp_valid", cpu_resp_valid, 0);
    check("r_rel_miss",       miss_count, 0);
    @(negedge clk);
    check("r_stale_no_fill",  fill_cycles, snap);
    check("r_stale_resp",     cpu_resp_valid, 0);

    // ---- Load miss 0x2C, memory answers on the fifth wait cycle ----
    issue(8'h2C, 1'b0, '0);
    check("m_lookup_en",   cache_en, 1);
    check("m_lookup_rw",   cache_rw, 0);
    check("m_lookup_addr", cache_addr, 8'h2C);
    @(negedge clk);
    check("m_check_resp", cpu_resp_valid, 0);
    @(negedge clk);
    check("m_mreq_valid", mem_req_valid, 1);
    check("m_mreq_we",    mem_we, 0);
    check("m_mreq_addr",  mem_addr, 8'h2C);
    check("m_miss",       miss_count, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("m_wait_resp", cpu_resp_valid, 0);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    check("m_fill_en",    cache_en, 1);
    check("m_fill_rw",    cache_rw, 1);
    check("m_fill_addr",  cache_addr, 8'h2C);
    check("m_fill_wdata", cache_wdata, 32'hDEAD_BEEF);
    check("m_fill_resp",  cpu_resp_valid, 0);
    @(negedge clk);
    check("m_resp_valid", cpu_resp_valid, 1);
    check("m_resp_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("m_resp_err",   cpu_resp_err, 0);
    check("m_resp_miss",  miss_count, 1);
    check("m_resp_hit",   hit_count, 0);
    @(negedge clk);
    check("m_after_resp",  cpu_resp_valid, 0);
    check("m_after_ready", cpu_req_ready, 1);

    // ---- Repeat load 0x2C hits: response three cycles after accept ----
    snap = mem_req_cycles;
    issue(8'h2C, 1'b0, '0);
    @(negedge clk);
    check("h_check_resp", cpu_resp_valid, 0);
    @(negedge clk);
    check("h_resp_valid", cpu_resp_valid, 1);
    check("h_resp_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("h_resp_err",   cpu_resp_err, 0);
    check("h_hit",        hit_count, 1);
    @(negedge clk);
    check("h_no_mem_req", mem_req_cycles, snap);
    check("h_after_resp", cpu_resp_valid, 0);

    // ---- Store 0x55AA55AA to 0x10, memory stalls ready for four edges ----
    issue(8'h10, 1'b1, 32'h55AA_55AA);
    check("s_lookup_rw",    cache_rw, 1);
    check("s_lookup_addr",  cache_addr, 8'h10);
    check("s_lookup_wdata", cache_wdata, 32'h55AA_55AA);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("s_hold_valid", mem_req_valid, 1);
      check("s_hold_we",    mem_we, 1);
      check("s_hold_addr",  mem_addr, 8'h10);
      check("s_hold_wdata", mem_wdata, 32'h55AA_55AA);
      @(negedge clk);
    end
    check("s_last_valid", mem_req_valid, 1);
    check("s_last_wdata", mem_wdata, 32'h55AA_55AA);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("s_resp_valid", cpu_resp_valid, 1);
    check("s_resp_err",   cpu_resp_err, 0);
    check("s_resp_rdata", cpu_rdata, 0);
    check("s_miss",       miss_count, 2);
    check("s_hit",        hit_count, 1);
    @(negedge clk);
    check("s_after_resp", cpu_resp_valid, 0);

    // ---- Timeout: load 0x80, memory never answers ----
    snap = fill_cycles;
    issue(8'h80, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    check("t_mreq_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (7) @(negedge clk);
    check("t_last_wait_resp", cpu_resp_valid, 0);
    @(negedge clk);
    check("t_resp_valid", cpu_resp_valid, 1);
    check("t_resp_err",   cpu_resp_err, 1);
    check("t_resp_rdata", cpu_rdata, 0);
    check("t_miss",       miss_count, 3);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    check("t_no_fill",     fill_cycles, snap);
    check("t_late_ignore", cpu_resp_valid, 0);
    check("t_late_en",     cache_en, 0);
    check("t_ready",       cpu_req_ready, 1);

    // ---- Response in exactly the timeout cycle; miss counter saturated ----
    issue(8'h90, 1'b0, '0);
    check("b_lookup_addr", cache_addr, 8'h90);
    @(negedge clk);
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (7) @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hCAFE_F00D;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    check("b_fill_en",    cache_en, 1);
    check("b_fill_rw",    cache_rw, 1);
    check("b_fill_addr",  cache_addr, 8'h90);
    check("b_fill_wdata", cache_wdata, 32'hCAFE_F00D);
    check("b_fill_resp",  cpu_resp_valid, 0);
    @(negedge clk);
    check("b_resp_valid", cpu_resp_valid, 1);
    check("b_resp_err",   cpu_resp_err, 0);
    check("b_resp_rdata", cpu_rdata, 32'hCAFE_F00D);
    check("b_miss_sat",   miss_count, 3);
    @(negedge clk);
    check("b_after_resp", cpu_resp_valid, 0);

    // ---- Hit counter saturation: reset, then five hits on 0x2C ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("sat_ready", cpu_req_ready, 1);
    check("sat_hit0",  hit_count, 0);
    check("sat_miss0", miss_count, 0);
    for (int i = 1; i <= 5; i++) begin
      issue(8'h2C, 1'b0, '0);
      @(negedge clk);
      @(negedge clk);
      check("sat_resp_valid", cpu_resp_valid, 1);
      check("sat_resp_rdata", cpu_rdata, 32'hDEAD_BEEF);
      check("sat_hit",        hit_count, (i > 3) ? 3 : i);
      @(negedge clk);
    end
    check("sat_miss_final", miss_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
